// File: rtl/mixer_cfg_master.sv
// mixer_cfg_master
//   Avalon-MM master that programs the VIP Mixer control slave. A pass stops
//   the mixer (addr 0 <- 0), writes X offset, Y offset and layer control for
//   each of NUM_LAYERS layers, optionally reads every layer word back and
//   rewrites it on mismatch, then re-enables the mixer (addr 0 <- 1).
//   A pass starts on the first cycle after reset when AUTO_START=1, and on
//   every start pulse seen while idle or faulted.
// Ports
//   clk, reset              clock, synchronous active-low reset
//   start                   pulse: begin a pass (ignored while busy)
//   x_offset, y_offset      packed per-layer offsets, layer i at [i*COORD_W +: COORD_W]
//   layer_en                per-layer control value
//   busy, done, fault       pass in progress / 1-cycle success pulse / sticky error
//   avm_m0_*                Avalon-MM master port (single-word transfers)
module mixer_cfg_master #(
   parameter int NUM_LAYERS   = 2,
   parameter int LAYER_BASE   = 8,
   parameter int LAYER_STRIDE = 5,
   parameter int COORD_W      = 12,
   parameter int VERIFY       = 1,
   parameter int MAX_RETRY    = 3,
   parameter int TIMEOUT      = 1024,
   parameter int AUTO_START   = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [NUM_LAYERS*COORD_W-1:0] x_offset,
   input  logic [NUM_LAYERS*COORD_W-1:0] y_offset,
   input  logic [NUM_LAYERS-1:0]         layer_en,
   output logic                          busy,
   output logic                          done,
   output logic                          fault,
   output logic [31:0]                   avm_m0_address,
   output logic                          avm_m0_read,
   output logic                          avm_m0_write,
   output logic [31:0]                   avm_m0_writedata,
   output logic [3:0]                    avm_m0_byteenable,
   output logic [10:0]                   avm_m0_burstcount,
   input  logic [31:0]                   avm_m0_readdata,
   input  logic                          avm_m0_readdatavalid,
   input  logic                          avm_m0_waitrequest
);

   localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef logic [NUM_LAYERS-1:0][COORD_W-1:0] coord_arr_t;

   typedef enum logic [2:0] {
      S_IDLE, S_STOP, S_WR, S_RD, S_RD_WAIT, S_ENABLE, S_DONE, S_FAULT
   } state_t;

   state_t                  state;
   coord_arr_t              x_snap, y_snap;
   logic [NUM_LAYERS-1:0]   en_snap;
   logic [LW-1:0]           layer;
   logic [1:0]              field;      // 0: X, 1: Y, 2: CTRL
   logic [RW-1:0]           retry;
   logic [TW-1:0]           tmo;
   logic                    auto_pend;

   function automatic logic [31:0] word_addr(input logic [LW-1:0] l, input logic [1:0] f);
      return 32'(LAYER_BASE) + 32'(l) * 32'(LAYER_STRIDE) + 32'(f);
   endfunction

   function automatic logic [31:0] word_data(input logic [LW-1:0] l, input logic [1:0] f,
                                             input coord_arr_t xs, input coord_arr_t ys,
                                             input logic [NUM_LAYERS-1:0] es);
      logic [LW-1:0] li;
      // adv_* may point one past the last layer; that value is never issued
      li = (32'(l) < 32'(NUM_LAYERS)) ? l : '0;
      case (f)
         2'd0:    return 32'(xs[li]);
         2'd1:    return 32'(ys[li]);
         default: return {31'b0, es[li]};
      endcase
   endfunction

   logic          last_word, tmo_hit;
   logic [LW-1:0] adv_layer;
   logic [1:0]    adv_field;
   logic [31:0]   cur_addr, cur_data, nxt_addr, nxt_data;

   // Next word after the current one is accepted (or verified); after the
   // final CTRL word the next request is the mixer enable.
   always_comb begin
      last_word = (field == 2'd2) && (32'(layer) == 32'(NUM_LAYERS - 1));
      tmo_hit   = (tmo == TW'(TIMEOUT - 1));
      adv_layer = layer;
      adv_field = field + 2'd1;
      if (field == 2'd2) begin
         adv_layer = layer + 1'b1;
         adv_field = 2'd0;
      end
      cur_addr = word_addr(layer, field);
      cur_data = word_data(layer, field, x_snap, y_snap, en_snap);
      nxt_addr = last_word ? 32'd0 : word_addr(adv_layer, adv_field);
      nxt_data = last_word ? 32'd1 : word_data(adv_layer, adv_field, x_snap, y_snap, en_snap);
   end

   assign avm_m0_byteenable = (avm_m0_read || avm_m0_write) ? 4'hF  : 4'h0;
   assign avm_m0_burstcount = (avm_m0_read || avm_m0_write) ? 11'd1 : 11'd0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state            <= S_IDLE;
         busy             <= 1'b0;
         done             <= 1'b0;
         fault            <= 1'b0;
         avm_m0_address   <= '0;
         avm_m0_read      <= 1'b0;
         avm_m0_write     <= 1'b0;
         avm_m0_writedata <= '0;
         x_snap           <= '0;
         y_snap           <= '0;
         en_snap          <= '0;
         layer            <= '0;
         field            <= '0;
         retry            <= '0;
         tmo              <= '0;
         auto_pend        <= (AUTO_START != 0);
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_FAULT: begin
               if (start || (state == S_IDLE && auto_pend)) begin
                  auto_pend        <= 1'b0;
                  state            <= S_STOP;
                  busy             <= 1'b1;
                  fault            <= 1'b0;
                  x_snap           <= x_offset;
                  y_snap           <= y_offset;
                  en_snap          <= layer_en;
                  layer            <= '0;
                  field            <= '0;
                  retry            <= '0;
                  tmo              <= '0;
                  avm_m0_write     <= 1'b1;
                  avm_m0_address   <= 32'd0;
                  avm_m0_writedata <= 32'd0;
               end
            end

            S_STOP, S_WR, S_RD, S_ENABLE: begin
               if (avm_m0_waitrequest) begin
                  if (tmo_hit) begin
                     state            <= S_FAULT;
                     fault            <= 1'b1;
                     busy             <= 1'b0;
                     avm_m0_read      <= 1'b0;
                     avm_m0_write     <= 1'b0;
                     avm_m0_address   <= '0;
                     avm_m0_writedata <= '0;
                  end else begin
                     tmo <= tmo + 1'b1;
                  end
               end else begin
                  tmo <= '0;
                  case (state)
                     S_STOP: begin
                        state            <= S_WR;
                        avm_m0_address   <= cur_addr;
                        avm_m0_writedata <= cur_data;
                     end
                     S_WR: begin
                        if (VERIFY != 0) begin
                           state            <= S_RD;
                           avm_m0_write     <= 1'b0;
                           avm_m0_read      <= 1'b1;
                           avm_m0_writedata <= '0;
                        end else begin
                           state            <= last_word ? S_ENABLE : S_WR;
                           layer            <= adv_layer;
                           field            <= adv_field;
                           avm_m0_address   <= nxt_addr;
                           avm_m0_writedata <= nxt_data;
                        end
                     end
                     S_RD: begin
                        // read accepted; the timeout keeps running until data returns
                        state          <= S_RD_WAIT;
                        avm_m0_read    <= 1'b0;
                        avm_m0_address <= '0;
                        tmo            <= tmo;
                     end
                     default: begin  // S_ENABLE
                        state            <= S_DONE;
                        done             <= 1'b1;
                        busy             <= 1'b0;
                        avm_m0_write     <= 1'b0;
                        avm_m0_address   <= '0;
                        avm_m0_writedata <= '0;
                     end
                  endcase
               end
            end

            S_RD_WAIT: begin
               if (avm_m0_readdatavalid) begin
                  tmo          <= '0;
                  avm_m0_write <= 1'b1;
                  if (avm_m0_readdata == cur_data) begin
                     state            <= last_word ? S_ENABLE : S_WR;
                     layer            <= adv_layer;
                     field            <= adv_field;
                     retry            <= '0;
                     avm_m0_address   <= nxt_addr;
                     avm_m0_writedata <= nxt_data;
                  end else if (retry == RW'(MAX_RETRY)) begin
                     state        <= S_FAULT;
                     fault        <= 1'b1;
                     busy         <= 1'b0;
                     avm_m0_write <= 1'b0;
                  end else begin
                     state            <= S_WR;
                     retry            <= retry + 1'b1;
                     avm_m0_address   <= cur_addr;
                     avm_m0_writedata <= cur_data;
                  end
               end else if (tmo_hit) begin
                  state <= S_FAULT;
                  fault <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end

            default: state <= S_IDLE;  // S_DONE
         endcase
      end
   end

endmodule

// File: tb/tb_mixer_cfg_master.sv
// tb_mixer_cfg_master
//   Directed bench for mixer_cfg_master (defaults, TIMEOUT=16). A behavioural
//   slave stores writes, answers reads one cycle later, and can stall a
//   chosen address or corrupt readbacks of a chosen address.
module tb_mixer_cfg_master;
   localparam int NL = 2;
   localparam int CW = 12;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [NL*CW-1:0]  x_offset = {12'h456, 12'h123};
   logic [NL*CW-1:0]  y_offset = {12'hABC, 12'h789};
   logic [NL-1:0]     layer_en = 2'b01;
   logic              busy, done, fault, rd, wr, wreq;
   logic              rdv = 1'b0;
   logic [31:0]       addr, wdata;
   logic [31:0]       rdata = '0;
   logic [3:0]        be;
   logic [10:0]       bc;

   always #5 clk = ~clk;

   mixer_cfg_master #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset), .start(start),
      .x_offset(x_offset), .y_offset(y_offset), .layer_en(layer_en),
      .busy(busy), .done(done), .fault(fault),
      .avm_m0_address(addr), .avm_m0_read(rd), .avm_m0_write(wr),
      .avm_m0_writedata(wdata), .avm_m0_byteenable(be), .avm_m0_burstcount(bc),
      .avm_m0_readdata(rdata), .avm_m0_readdatavalid(rdv), .avm_m0_waitrequest(wreq)
   );

   // slave: counters only grow; the stimulus moves the limits
   logic [31:0] mem [0:31];
   logic [31:0] stall_addr = '1;
   int          stall_cnt = 0, stall_lim = 0;
   logic [31:0] bad_addr = '1;
   int          bad_used = 0, bad_lim = 0;
   logic [31:0] qa[$], qd[$];
   int          done_cnt = 0, unstable = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_a = '0, prev_d = '0;

   assign wreq = wr && (addr == stall_addr) && (stall_cnt < stall_lim);

   always @(posedge clk) begin
      rdv <= 1'b0;
      if (wreq) stall_cnt <= stall_cnt + 1;
      if (wr && !wreq) begin
         mem[addr[4:0]] <= wdata;
         qa.push_back(addr);
         qd.push_back(wdata);
      end
      if (rd) begin
         rdv <= 1'b1;
         if (addr == bad_addr && bad_used < bad_lim) begin
            rdata    <= 32'hDEAD;
            bad_used <= bad_used + 1;
         end else begin
            rdata <= mem[addr[4:0]];
         end
      end
      if (done) done_cnt <= done_cnt + 1;
      if (prev_stall && (!wr || addr !== prev_a || wdata !== prev_d)) unstable <= unstable + 1;
      prev_stall <= wreq;
      prev_a     <= addr;
      prev_d     <= wdata;
   end

   int          errors = 0, checks = 0;
   logic [31:0] ea[$], ed[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic exp_w(input logic [31:0] a, input logic [31:0] d);
      ea.push_back(a);
      ed.push_back(d);
   endtask

   task automatic exp_pass();
      exp_w(32'h0, 32'h0);   exp_w(32'h8, 32'h123); exp_w(32'h9, 32'h789); exp_w(32'hA, 32'h1);
      exp_w(32'hD, 32'h456); exp_w(32'hE, 32'hABC); exp_w(32'hF, 32'h0);   exp_w(32'h0, 32'h1);
   endtask

   task automatic chk_log(input string tag, input int base);
      chk($sformatf("%s_len", tag), 32'(qa.size() - base), 32'(ea.size()));
      for (int i = 0; i < ea.size(); i++) begin
         if (base + i < qa.size()) begin
            chk($sformatf("%s_addr%0d", tag, i), qa[base+i], ea[i]);
            chk($sformatf("%s_data%0d", tag, i), qd[base+i], ed[i]);
         end
      end
      ea.delete();
      ed.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int d0 = done_cnt;
      int n  = 0;
      while (done_cnt == d0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done_cnt != d0), 32'd1);
   endtask

   task automatic chk_bus_idle(input string tag);
      chk({tag, "_busy"},  32'(busy),  32'd0);
      chk({tag, "_done"},  32'(done),  32'd0);
      chk({tag, "_fault"}, 32'(fault), 32'd0);
      chk({tag, "_wr"},    32'(wr),    32'd0);
      chk({tag, "_rd"},    32'(rd),    32'd0);
      chk({tag, "_addr"},  addr,       32'd0);
      chk({tag, "_wdata"}, wdata,      32'd0);
      chk({tag, "_be"},    32'(be),    32'd0);
      chk({tag, "_bc"},    32'(bc),    32'd0);
   endtask

   initial begin
      int base, s0, u0, n;

      // reset state
      repeat (3) @(negedge clk);
      chk_bus_idle("rst");

      // auto-start pass; input change after the snapshot must be ignored
      reset = 1'b1;
      @(negedge clk);
      chk("auto_busy", 32'(busy), 32'd1);
      chk("auto_wr",   32'(wr),   32'd1);
      chk("auto_addr", addr,      32'd0);
      chk("auto_be",   32'(be),   32'hF);
      chk("auto_bc",   32'(bc),   32'd1);
      x_offset[11:0] = 12'hFFF;
      wait_done("auto_done");
      x_offset[11:0] = 12'h123;
      exp_pass();
      chk_log("auto", 0);
      repeat (3) @(negedge clk);
      chk("auto_done_cnt", 32'(done_cnt), 32'd1);
      chk("auto_fault",    32'(fault),    32'd0);
      chk("auto_idle",     32'(busy),     32'd0);

      // waitrequest high for 5 cycles on address 9
      stall_addr = 32'h9;
      stall_lim  = stall_cnt + 5;
      s0 = stall_cnt; u0 = unstable; base = qa.size();
      pulse_start();
      wait_done("stall_done");
      exp_pass();
      chk_log("stall", base);
      chk("stall_cycles", 32'(stall_cnt - s0), 32'd5);
      chk("stall_stable", 32'(unstable - u0),  32'd0);
      stall_addr = '1;

      // one bad readback of address D -> one rewrite
      bad_addr = 32'hD;
      bad_lim  = bad_used + 1;
      base = qa.size();
      pulse_start();
      wait_done("retry_done");
      exp_w(32'h0, 32'h0);   exp_w(32'h8, 32'h123); exp_w(32'h9, 32'h789); exp_w(32'hA, 32'h1);
      exp_w(32'hD, 32'h456); exp_w(32'hD, 32'h456); exp_w(32'hE, 32'hABC); exp_w(32'hF, 32'h0);
      exp_w(32'h0, 32'h1);
      chk_log("retry", base);
      chk("retry_fault", 32'(fault), 32'd0);

      // address E never verifies -> 1 write + 3 rewrites, then fault
      bad_addr = 32'hE;
      bad_lim  = bad_used + 1000;
      base = qa.size();
      pulse_start();
      n = 0;
      while (!fault && n < 500) begin @(negedge clk); n++; end
      chk("mis_fault_seen", 32'(fault), 32'd1);
      repeat (4) @(negedge clk);
      exp_w(32'h0, 32'h0);   exp_w(32'h8, 32'h123); exp_w(32'h9, 32'h789); exp_w(32'hA, 32'h1);
      exp_w(32'hD, 32'h456); exp_w(32'hE, 32'hABC); exp_w(32'hE, 32'hABC); exp_w(32'hE, 32'hABC);
      exp_w(32'hE, 32'hABC);
      chk_log("mis", base);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_busy",  32'(busy),  32'd0);
      chk("mis_wr",    32'(wr),    32'd0);
      chk("mis_rd",    32'(rd),    32'd0);
      bad_lim = bad_used;

      // waitrequest stuck at address A -> timeout after 16 cycles
      stall_addr = 32'hA;
      stall_lim  = stall_cnt + 1000;
      pulse_start();
      chk("tmo_fault_clr", 32'(fault), 32'd0);
      n = 0;
      while (!(wr && addr == 32'hA) && n < 200) begin @(negedge clk); n++; end
      n = 0;
      while (wr && addr == 32'hA && n < 100) begin @(negedge clk); n++; end
      chk("tmo_cycles", 32'(n),     32'd16);
      chk("tmo_fault",  32'(fault), 32'd1);
      chk("tmo_busy",   32'(busy),  32'd0);
      chk("tmo_wr",     32'(wr),    32'd0);
      stall_lim = stall_cnt;
      base = qa.size();
      pulse_start();
      chk("rerun_fault", 32'(fault), 32'd0);
      chk("rerun_busy",  32'(busy),  32'd1);
      chk("rerun_wr",    32'(wr),    32'd1);
      chk("rerun_addr",  addr,       32'd0);
      chk("rerun_wdata", wdata,      32'd0);
      wait_done("rerun_done");
      exp_pass();
      chk_log("rerun", base);

      // reset during layer-1 Y write, then auto-start again
      pulse_start();
      n = 0;
      while (!(wr && addr == 32'hE) && n < 200) begin @(negedge clk); n++; end
      chk("mid_reached", 32'(wr && addr == 32'hE), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk_bus_idle("mid_rst");
      @(negedge clk);
      base = qa.size();
      reset = 1'b1;
      wait_done("mid_done");
      exp_pass();
      chk_log("mid", base);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
      $fatal(1);
   end
endmodule
